id_stage: RTL and testbench

- Decode stage; sits directly downstream of the fetch stage.
- Consumes IF_ID_PC / IF_ID_Instruction and decodes RV32I fields, immediates and control.
- Drives register-file read addresses, detects load-use hazards, and registers everything into the ID/EX pipeline register.
- One-cycle latency; the register file itself is external.

---
 rtl/id_stage.sv | 254 +++++++++++++++++++++++++
 tb/tb_id_stage.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// RV32I decode stage: field/immediate/control decode, load-use hazard detect, ID/EX register.
// Optional macro ID_WB_BYPASS_EN adds a writeback-to-decode operand bypass (wb_we/wb_rd/wb_data).
module id_stage #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] IF_ID_PC,
    input  logic [31:0]     IF_ID_Instruction,
    input  logic            IF_ID_valid,
    input  logic            combined_stall,
    input  logic            flush,
`ifdef ID_WB_BYPASS_EN
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
`endif
    output logic [4:0]      rf_rs1_addr,
    output logic [4:0]      rf_rs2_addr,
    input  logic [XLEN-1:0] rf_rs1_data,
    input  logic [XLEN-1:0] rf_rs2_data,
    output logic            load_use_stall,
    output logic [XLEN-1:0] ID_EX_PC,
    output logic [XLEN-1:0] ID_EX_rs1_data,
    output logic [XLEN-1:0] ID_EX_rs2_data,
    output logic [XLEN-1:0] ID_EX_imm,
    output logic [4:0]      ID_EX_rs1,
    output logic [4:0]      ID_EX_rs2,
    output logic [4:0]      ID_EX_rd,
    output logic [2:0]      ID_EX_funct3,
    output logic [3:0]      ID_EX_alu_op,
    output logic            ID_EX_alu_src_a,
    output logic            ID_EX_alu_src_b,
    output logic            ID_EX_MemRead,
    output logic            ID_EX_MemWrite,
    output logic            ID_EX_RegWrite,
    output logic            ID_EX_MemToReg,
    output logic            ID_EX_Branch,
    output logic            ID_EX_Jump,
    output logic            ID_EX_JumpReg,
    output logic            ID_EX_valid,
    output logic            ID_EX_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASS_B = 4'd10;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [3:0]      alu_op;
        logic            alu_src_a;
        logic            alu_src_b;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
        logic            mem_to_reg;
        logic            branch;
        logic            jump;
        logic            jump_reg;
        logic            valid;
        logic            illegal;
    } idex_t;

    function automatic logic signed [31:0] imm_i(input logic [31:0] ins);
        imm_i = {{20{ins[31]}}, ins[31:20]};
    endfunction

    function automatic logic signed [31:0] imm_s(input logic [31:0] ins);
        imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    endfunction

    function automatic logic signed [31:0] imm_b(input logic [31:0] ins);
        imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    function automatic logic signed [31:0] imm_u(input logic [31:0] ins);
        imm_u = {ins[31:12], 12'b0};
    endfunction

    function automatic logic signed [31:0] imm_j(input logic [31:0] ins);
        imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

    // funct7[5] (instr[30]) picks SUB only for register ops; it always picks SRA on funct3=5
    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt, input logic is_reg);
        case (f3)
            3'd0:    alu_sel = (alt && is_reg) ? ALU_SUB : ALU_ADD;
            3'd1:    alu_sel = ALU_SLL;
            3'd2:    alu_sel = ALU_SLT;
            3'd3:    alu_sel = ALU_SLTU;
            3'd4:    alu_sel = ALU_XOR;
            3'd5:    alu_sel = alt ? ALU_SRA : ALU_SRL;
            3'd6:    alu_sel = ALU_OR;
            default: alu_sel = ALU_AND;
        endcase
    endfunction

    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [XLEN-1:0] rs1_val_p0;
    logic [XLEN-1:0] rs2_val_p0;
    logic            use_rs1_p0;
    logic            use_rs2_p0;
    idex_t           dec_p0;
    idex_t           idex_p1;

    assign instr       = IF_ID_Instruction;
    assign opcode      = instr[6:0];
    assign rf_rs1_addr = instr[19:15];
    assign rf_rs2_addr = instr[24:20];

`ifdef ID_WB_BYPASS_EN
    assign rs1_val_p0 = (wb_we && wb_rd != 5'd0 && wb_rd == rf_rs1_addr) ? wb_data : rf_rs1_data;
    assign rs2_val_p0 = (wb_we && wb_rd != 5'd0 && wb_rd == rf_rs2_addr) ? wb_data : rf_rs2_data;
`else
    assign rs1_val_p0 = rf_rs1_data;
    assign rs2_val_p0 = rf_rs2_data;
`endif

    // ---- stage p0: decode ----
    always_comb begin
        dec_p0          = '0;
        use_rs1_p0      = 1'b1;
        use_rs2_p0      = 1'b0;
        dec_p0.pc       = IF_ID_PC;
        dec_p0.rs1      = instr[19:15];
        dec_p0.rs2      = instr[24:20];
        dec_p0.rd       = instr[11:7];
        dec_p0.funct3   = instr[14:12];
        dec_p0.rs1_data = rs1_val_p0;
        dec_p0.rs2_data = rs2_val_p0;
        dec_p0.valid    = 1'b1;
        case (opcode)
            OPC_OP: begin
                dec_p0.alu_op    = alu_sel(instr[14:12], instr[30], 1'b1);
                dec_p0.reg_write = 1'b1;
                use_rs2_p0       = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_p0.alu_op    = alu_sel(instr[14:12], instr[30], 1'b0);
                dec_p0.imm       = imm_i(instr);
                dec_p0.alu_src_b = 1'b1;
                dec_p0.reg_write = 1'b1;
            end
            OPC_LOAD: begin
                dec_p0.imm        = imm_i(instr);
                dec_p0.mem_read   = 1'b1;
                dec_p0.reg_write  = 1'b1;
                dec_p0.mem_to_reg = 1'b1;
                dec_p0.alu_src_b  = 1'b1;
            end
            OPC_STORE: begin
                dec_p0.imm       = imm_s(instr);
                dec_p0.mem_write = 1'b1;
                dec_p0.alu_src_b = 1'b1;
                use_rs2_p0       = 1'b1;
            end
            OPC_BRANCH: begin
                dec_p0.imm    = imm_b(instr);
                dec_p0.alu_op = ALU_SUB;
                dec_p0.branch = 1'b1;
                use_rs2_p0    = 1'b1;
            end
            OPC_JAL: begin
                dec_p0.imm       = imm_j(instr);
                dec_p0.jump      = 1'b1;
                dec_p0.reg_write = 1'b1;
                dec_p0.alu_src_a = 1'b1;
                use_rs1_p0       = 1'b0;
            end
            OPC_JALR: begin
                dec_p0.imm       = imm_i(instr);
                dec_p0.jump      = 1'b1;
                dec_p0.jump_reg  = 1'b1;
                dec_p0.reg_write = 1'b1;
                dec_p0.alu_src_b = 1'b1;
            end
            OPC_AUIPC: begin
                dec_p0.imm       = imm_u(instr);
                dec_p0.alu_src_a = 1'b1;
                dec_p0.alu_src_b = 1'b1;
                dec_p0.reg_write = 1'b1;
                use_rs1_p0       = 1'b0;
            end
            OPC_LUI: begin
                dec_p0.imm       = imm_u(instr);
                dec_p0.alu_op    = ALU_PASS_B;
                dec_p0.alu_src_b = 1'b1;
                dec_p0.reg_write = 1'b1;
                use_rs1_p0       = 1'b0;
            end
            default: dec_p0.illegal = 1'b1;
        endcase
        if (dec_p0.rd == 5'd0) dec_p0.reg_write = 1'b0;
        if (!IF_ID_valid || instr == NOP_INSTR) dec_p0 = '0;
    end

    assign load_use_stall = !flush && idex_p1.valid && idex_p1.mem_read && (idex_p1.rd != 5'd0)
                            && IF_ID_valid
                            && ((use_rs1_p0 && rf_rs1_addr == idex_p1.rd)
                             || (use_rs2_p0 && rf_rs2_addr == idex_p1.rd));

    // ---- stage p1: ID/EX register ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_p1 <= '0;
        end else if (flush) begin
            idex_p1 <= '0;
        end else if (!combined_stall) begin
            idex_p1 <= load_use_stall ? '0 : dec_p0;
        end
    end

    assign ID_EX_PC        = idex_p1.pc;
    assign ID_EX_rs1_data  = idex_p1.rs1_data;
    assign ID_EX_rs2_data  = idex_p1.rs2_data;
    assign ID_EX_imm       = idex_p1.imm;
    assign ID_EX_rs1       = idex_p1.rs1;
    assign ID_EX_rs2       = idex_p1.rs2;
    assign ID_EX_rd        = idex_p1.rd;
    assign ID_EX_funct3    = idex_p1.funct3;
    assign ID_EX_alu_op    = idex_p1.alu_op;
    assign ID_EX_alu_src_a = idex_p1.alu_src_a;
    assign ID_EX_alu_src_b = idex_p1.alu_src_b;
    assign ID_EX_MemRead   = idex_p1.mem_read;
    assign ID_EX_MemWrite  = idex_p1.mem_write;
    assign ID_EX_RegWrite  = idex_p1.reg_write;
    assign ID_EX_MemToReg  = idex_p1.mem_to_reg;
    assign ID_EX_Branch    = idex_p1.branch;
    assign ID_EX_Jump      = idex_p1.jump;
    assign ID_EX_JumpReg   = idex_p1.jump_reg;
    assign ID_EX_valid     = idex_p1.valid;
    assign ID_EX_illegal   = idex_p1.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Randomized self-checking bench for id_stage against a behavioural decode model.
// Covers the ID_WB_BYPASS_EN variant when that macro is defined.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_Instruction;
    logic        IF_ID_valid;
    logic        combined_stall;
    logic        flush;
`ifdef ID_WB_BYPASS_EN
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
`endif
    logic [4:0]  rf_rs1_addr, rf_rs2_addr;
    logic [31:0] rf_rs1_data, rf_rs2_data;
    logic        load_use_stall;
    logic [31:0] ID_EX_PC, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;
    logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
    logic [2:0]  ID_EX_funct3;
    logic [3:0]  ID_EX_alu_op;
    logic        ID_EX_alu_src_a, ID_EX_alu_src_b, ID_EX_MemRead, ID_EX_MemWrite;
    logic        ID_EX_RegWrite, ID_EX_MemToReg, ID_EX_Branch, ID_EX_Jump, ID_EX_JumpReg;
    logic        ID_EX_valid, ID_EX_illegal;

    logic [31:0] regs [32];
    int          checks = 0;
    int          errors = 0;
    logic        cmp_en = 1'b0;

    assign rf_rs1_data = regs[IF_ID_Instruction[19:15]];
    assign rf_rs2_data = regs[IF_ID_Instruction[24:20]];

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .reset(reset), .IF_ID_PC(IF_ID_PC), .IF_ID_Instruction(IF_ID_Instruction),
        .IF_ID_valid(IF_ID_valid), .combined_stall(combined_stall), .flush(flush),
`ifdef ID_WB_BYPASS_EN
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
`endif
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .load_use_stall(load_use_stall),
        .ID_EX_PC(ID_EX_PC), .ID_EX_rs1_data(ID_EX_rs1_data), .ID_EX_rs2_data(ID_EX_rs2_data),
        .ID_EX_imm(ID_EX_imm), .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
        .ID_EX_funct3(ID_EX_funct3), .ID_EX_alu_op(ID_EX_alu_op),
        .ID_EX_alu_src_a(ID_EX_alu_src_a), .ID_EX_alu_src_b(ID_EX_alu_src_b),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MemWrite(ID_EX_MemWrite),
        .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemToReg(ID_EX_MemToReg),
        .ID_EX_Branch(ID_EX_Branch), .ID_EX_Jump(ID_EX_Jump), .ID_EX_JumpReg(ID_EX_JumpReg),
        .ID_EX_valid(ID_EX_valid), .ID_EX_illegal(ID_EX_illegal)
    );

    typedef struct packed {
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [3:0]  op;
        logic        sa, sb, mr, mw, rw, m2r, br, j, jr, v, ill;
    } exp_t;

    exp_t m;
    int   alu_tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] src(input logic [4:0] a);
        logic [31:0] d;
        d = regs[a];
`ifdef ID_WB_BYPASS_EN
        if (wb_we && wb_rd != 0 && wb_rd == a) d = wb_data;
`endif
        return d;
    endfunction

    function automatic exp_t decode_m(input logic [31:0] ins, input logic [31:0] pc, input logic v);
        exp_t        e;
        logic [31:0] sx;
        int          f3;
        logic        alt;
        e   = '0;
        sx  = ins;
        f3  = int'(ins[14:12]);
        alt = ins[30];
        if (!v || ins == 32'h0000_0013) return e;
        e.v = 1; e.pc = pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        e.f3 = ins[14:12]; e.rs1d = src(ins[19:15]); e.rs2d = src(ins[24:20]);
        case (ins[6:0])
            7'h33: begin
                e.op = 4'(alu_tab[f3]);
                if (alt && f3 == 0) e.op = 1;
                if (alt && f3 == 5) e.op = 7;
                e.rw = 1;
            end
            7'h13: begin
                e.op = 4'(alu_tab[f3]);
                if (alt && f3 == 5) e.op = 7;
                e.imm = 32'($signed(sx) >>> 20); e.sb = 1; e.rw = 1;
            end
            7'h03: begin e.imm = 32'($signed(sx) >>> 20); e.mr = 1; e.rw = 1; e.m2r = 1; e.sb = 1; end
            7'h23: begin
                e.imm = (32'($signed(sx) >>> 25) << 5) | 32'(ins[11:7]);
                e.mw = 1; e.sb = 1;
            end
            7'h63: begin
                e.imm = (32'($signed(sx) >>> 31) << 12) | (32'(ins[7]) << 11)
                      | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
                e.op = 1; e.br = 1;
            end
            7'h6F: begin
                e.imm = (32'($signed(sx) >>> 31) << 20) | (32'(ins[19:12]) << 12)
                      | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
                e.j = 1; e.rw = 1; e.sa = 1;
            end
            7'h67: begin e.imm = 32'($signed(sx) >>> 20); e.j = 1; e.jr = 1; e.rw = 1; e.sb = 1; end
            7'h17: begin e.imm = ins & 32'hFFFF_F000; e.sa = 1; e.sb = 1; e.rw = 1; end
            7'h37: begin e.imm = ins & 32'hFFFF_F000; e.op = 10; e.sb = 1; e.rw = 1; end
            default: e.ill = 1;
        endcase
        if (e.rd == 0) e.rw = 0;
        return e;
    endfunction

    function automatic logic exp_stall();
        logic [6:0] o;
        logic       u1, u2;
        o  = IF_ID_Instruction[6:0];
        u1 = !(o == 7'h37 || o == 7'h17 || o == 7'h6F);
        u2 = (o == 7'h33 || o == 7'h23 || o == 7'h63);
        return !flush && m.v && m.mr && m.rd != 0 && IF_ID_valid &&
               ((u1 && IF_ID_Instruction[19:15] == m.rd) || (u2 && IF_ID_Instruction[24:20] == m.rd));
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset)               m <= '0;
        else if (flush)          m <= '0;
        else if (combined_stall) m <= m;
        else if (exp_stall())    m <= '0;
        else                     m <= decode_m(IF_ID_Instruction, IF_ID_PC, IF_ID_valid);
    end

    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            chk("rs1_addr", rf_rs1_addr, IF_ID_Instruction[19:15]);
            chk("rs2_addr", rf_rs2_addr, IF_ID_Instruction[24:20]);
            chk("load_use_stall", load_use_stall, exp_stall());
            chk("pc", ID_EX_PC, m.pc);
            chk("rs1_data", ID_EX_rs1_data, m.rs1d);
            chk("rs2_data", ID_EX_rs2_data, m.rs2d);
            chk("imm", ID_EX_imm, m.imm);
            chk("rs1", ID_EX_rs1, m.rs1);
            chk("rs2", ID_EX_rs2, m.rs2);
            chk("rd", ID_EX_rd, m.rd);
            chk("funct3", ID_EX_funct3, m.f3);
            chk("alu_op", ID_EX_alu_op, m.op);
            chk("ctrl", {ID_EX_alu_src_a, ID_EX_alu_src_b, ID_EX_MemRead, ID_EX_MemWrite,
                         ID_EX_RegWrite, ID_EX_MemToReg, ID_EX_Branch, ID_EX_Jump, ID_EX_JumpReg},
                {m.sa, m.sb, m.mr, m.mw, m.rw, m.m2r, m.br, m.j, m.jr});
            chk("valid", ID_EX_valid, m.v);
            chk("illegal", ID_EX_illegal, m.ill);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [6:0]  opcs [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
        logic [31:0] ins;
        ins        = $urandom;
        ins[6:0]   = opcs[$urandom_range(0, 9)];
        if ($urandom_range(0, 3) == 0) ins[6:0] = 7'h03;
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        ins[11:7]  = 5'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) ins = 32'h0000_0013;
        return ins;
    endfunction

    logic hold;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        reset = 1'b1; IF_ID_PC = 0; IF_ID_Instruction = 32'h13; IF_ID_valid = 0;
        combined_stall = 0; flush = 0;
`ifdef ID_WB_BYPASS_EN
        wb_we = 0; wb_rd = 0; wb_data = 0;
`endif
        step(); step();
        chk("reset_valid", ID_EX_valid, 0);
        chk("reset_pc", ID_EX_PC, 0);
        reset = 1'b0;
        cmp_en = 1'b1;

        // ADDI x5,x1,-1
        regs[1] = 32'd10; IF_ID_PC = 32'h40; IF_ID_Instruction = 32'hFFF0_8293; IF_ID_valid = 1;
        step();
        chk("addi_imm", ID_EX_imm, 32'hFFFF_FFFF);
        chk("addi_alu_op", ID_EX_alu_op, 0);
        chk("addi_src_b", ID_EX_alu_src_b, 1);
        chk("addi_regwrite", ID_EX_RegWrite, 1);
        chk("addi_rd", ID_EX_rd, 5);
        chk("addi_rs1_data", ID_EX_rs1_data, 10);

        // LW x6,0(x2) then ADD x7,x6,x3
        IF_ID_PC = 32'h44; IF_ID_Instruction = 32'h0001_2303;
        step();
        IF_ID_PC = 32'h48; IF_ID_Instruction = 32'h0033_03B3;
        #1 chk("lu_stall_on", load_use_stall, 1);
        step();
        chk("lu_bubble_valid", ID_EX_valid, 0);
        #1 chk("lu_stall_off", load_use_stall, 0);
        step();
        chk("lu_add_valid", ID_EX_valid, 1);
        chk("lu_add_rs1", ID_EX_rs1, 6);
        chk("lu_add_rd", ID_EX_rd, 7);

        // BEQ x1,x2,-4 flushed, then captured
        IF_ID_PC = 32'h100; IF_ID_Instruction = 32'hFE20_8EE3; flush = 1;
        step();
        flush = 0;
        chk("flush_valid", ID_EX_valid, 0);
        chk("flush_branch", ID_EX_Branch, 0);
        step();
        chk("beq_branch", ID_EX_Branch, 1);
        chk("beq_imm", ID_EX_imm, 32'hFFFF_FFFC);
        chk("beq_alu_op", ID_EX_alu_op, 1);

        // hold for 3 cycles with a new instruction presented
        IF_ID_PC = 32'h104; IF_ID_Instruction = 32'hFFF0_8293; combined_stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_pc", ID_EX_PC, 32'h100);
            chk("hold_branch", ID_EX_Branch, 1);
        end
        combined_stall = 0;
        step();
        chk("release_pc", ID_EX_PC, 32'h104);
        chk("release_regwrite", ID_EX_RegWrite, 1);

        // unknown opcode with rd=x6
        IF_ID_PC = 32'h108; IF_ID_Instruction = 32'h0000_037F;
        step();
        chk("ill_valid", ID_EX_valid, 1);
        chk("ill_flag", ID_EX_illegal, 1);
        chk("ill_ctrl", {ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_Jump,
                         ID_EX_Branch, ID_EX_alu_src_b}, 0);

`ifdef ID_WB_BYPASS_EN
        wb_we = 1; wb_rd = 1; wb_data = 32'h55; IF_ID_Instruction = 32'hFFF0_8293;
        step();
        chk("bypass_rs1", ID_EX_rs1_data, 32'h55);
        wb_we = 0;
`endif

        // reset mid-operation with a valid ADD in ID/EX
        IF_ID_PC = 32'h10C; IF_ID_Instruction = 32'h0033_03B3;
        step();
        chk("pre_reset_valid", ID_EX_valid, 1);
        reset = 1;
        #1;
        chk("async_reset_valid", ID_EX_valid, 0);
        chk("async_reset_pc", ID_EX_PC, 0);
        chk("async_reset_regwrite", ID_EX_RegWrite, 0);
        step();
        reset = 0;

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            hold = combined_stall || exp_stall();
            step();
            combined_stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 15) == 0);
            regs[$urandom_range(0, 31)] = $urandom;
`ifdef ID_WB_BYPASS_EN
            wb_we = $urandom_range(0, 1) == 1;
            wb_rd = 5'($urandom_range(0, 3));
            wb_data = $urandom;
`endif
            if (!hold) begin
                IF_ID_Instruction = gen_instr();
                IF_ID_PC = IF_ID_PC + 4;
                IF_ID_valid = ($urandom_range(0, 7) != 0);
            end
        end
        step();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
